// File: rtl/stdp_synapse.sv
// stdp_synapse: one plastic synapse with trace-based pair STDP.
// A presynaptic spike emits a one-cycle current equal to the stored weight.
// With STDP_LEARN_EN defined, pre/post eligibility traces and the online
// weight update are built. Without it, the weight changes only through the
// host load port and both traces read 0.
`timescale 1ns/1ps
module stdp_synapse #(
    parameter logic [7:0] INIT_WEIGHT = 8'd50,
    parameter logic [7:0] W_MAX       = 8'd255,
    parameter logic [7:0] A_PLUS      = 8'd4,
    parameter logic [7:0] A_MINUS     = 8'd3,
    parameter logic [7:0] TRACE_MAX   = 8'd20,
    parameter logic [7:0] TRACE_DECAY = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_spike,
    input  logic       post_spike,
    input  logic       learn_en,
    input  logic       weight_load,
    input  logic [7:0] weight_din,
    output logic [7:0] input_current,
    output logic [7:0] weight,
    output logic [7:0] pre_trace,
    output logic [7:0] post_trace
);

    logic [7:0] r_weight;
    logic [7:0] r_current;
    logic [7:0] w_learn_weight;
    logic [7:0] w_weight_next;

`ifdef STDP_LEARN_EN
    logic [7:0]        r_pre_trace;
    logic [7:0]        r_post_trace;
    logic [8:0]        w_pre_dec;
    logic [8:0]        w_post_dec;
    logic [7:0]        w_pre_next;
    logic [7:0]        w_post_next;
    logic [7:0]        w_ltp;
    logic [7:0]        w_ltd;
    logic signed [9:0] w_sum;

    // Trace next values: reload on own spike, otherwise saturating decay
    always_comb begin
        w_pre_dec  = {1'b0, r_pre_trace}  - {1'b0, TRACE_DECAY};
        w_post_dec = {1'b0, r_post_trace} - {1'b0, TRACE_DECAY};
        w_pre_next  = w_pre_dec[8]  ? '0 : w_pre_dec[7:0];
        w_post_next = w_post_dec[8] ? '0 : w_post_dec[7:0];
        if (pre_spike) begin
            w_pre_next = TRACE_MAX;
        end
        if (post_spike) begin
            w_post_next = TRACE_MAX;
        end
    end

    // Trace registers, updated regardless of learn_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_trace  <= '0;
            r_post_trace <= '0;
        end else begin
            r_pre_trace  <= w_pre_next;
            r_post_trace <= w_post_next;
        end
    end

    // STDP update on the old traces, so a spike never pairs with its own trace load
    always_comb begin
        w_ltp = (learn_en && post_spike && (r_pre_trace  != '0)) ? A_PLUS  : '0;
        w_ltd = (learn_en && pre_spike  && (r_post_trace != '0)) ? A_MINUS : '0;
        w_sum = $signed({2'b00, r_weight}) + $signed({2'b00, w_ltp})
              - $signed({2'b00, w_ltd});
        w_learn_weight = r_weight;
        if (learn_en) begin
            if (w_sum < 0) begin
                w_learn_weight = '0;
            end else if (w_sum > $signed({2'b00, W_MAX})) begin
                w_learn_weight = W_MAX;
            end else begin
                w_learn_weight = w_sum[7:0];
            end
        end
    end

    assign pre_trace  = r_pre_trace;
    assign post_trace = r_post_trace;
`else
    logic w_unused;

    assign w_learn_weight = r_weight;
    assign pre_trace      = '0;
    assign post_trace     = '0;
    assign w_unused = &{1'b0, learn_en, post_spike, A_PLUS, A_MINUS,
                        TRACE_MAX, TRACE_DECAY};
`endif

    // Host load takes priority over learning and is clamped to W_MAX
    always_comb begin
        w_weight_next = w_learn_weight;
        if (weight_load) begin
            w_weight_next = (weight_din > W_MAX) ? W_MAX : weight_din;
        end
    end

    // Weight register and one-cycle current from the pre-edge weight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight  <= INIT_WEIGHT;
            r_current <= '0;
        end else begin
            r_weight  <= w_weight_next;
            r_current <= pre_spike ? r_weight : '0;
        end
    end

    assign weight        = r_weight;
    assign input_current = r_current;

endmodule

// File: tb/tb_stdp_synapse.sv
// tb_stdp_synapse: directed self-checking bench for stdp_synapse.
// Expectations adapt to whether STDP_LEARN_EN is defined in the build.
`timescale 1ns/1ps
module tb_stdp_synapse;

`ifdef STDP_LEARN_EN
    localparam bit LEARN = 1'b1;
`else
    localparam bit LEARN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_spike, post_spike, learn_en, weight_load;
    logic [7:0] weight_din;
    logic [7:0] input_current, weight, pre_trace, post_trace;
    logic [7:0] c2_current, c2_weight, c2_pre, c2_post;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stdp_synapse dut (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .post_spike(post_spike),
        .learn_en(learn_en), .weight_load(weight_load), .weight_din(weight_din),
        .input_current(input_current), .weight(weight),
        .pre_trace(pre_trace), .post_trace(post_trace)
    );

    stdp_synapse #(.W_MAX(8'd200)) dut_wmax (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .post_spike(post_spike),
        .learn_en(learn_en), .weight_load(weight_load), .weight_din(weight_din),
        .input_current(c2_current), .weight(c2_weight),
        .pre_trace(c2_pre), .post_trace(c2_post)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pre_spike   = 1'b0;
        post_spike  = 1'b0;
        weight_load = 1'b0;
        weight_din  = 8'd0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_weight(input logic [7:0] v);
        clear_inputs();
        weight_load = 1'b1;
        weight_din  = v;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pre_spike   = 1'($urandom_range(0, 1));
            post_spike  = 1'($urandom_range(0, 1));
            learn_en    = 1'($urandom_range(0, 1));
            weight_load = 1'($urandom_range(0, 1));
            weight_din  = 8'($urandom_range(0, 255));
            tick();
            checks++;
            if (weight !== 8'd50 || input_current !== 8'd0 ||
                pre_trace !== 8'd0 || post_trace !== 8'd0) begin
                errors++;
                $display("FAIL reset_during: w=%0d cur=%0d pt=%0d qt=%0d want 50/0/0/0",
                         weight, input_current, pre_trace, post_trace);
            end
        end
        clear_inputs();
        learn_en = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (weight !== 8'd50 || input_current !== 8'd0 ||
            pre_trace !== 8'd0 || post_trace !== 8'd0) begin
            errors++;
            $display("FAIL reset_after: w=%0d cur=%0d pt=%0d qt=%0d want 50/0/0/0",
                     weight, input_current, pre_trace, post_trace);
        end
    endtask

    task automatic test_current_and_trace();
        learn_en  = 1'b0;
        pre_spike = 1'b1;
        tick();
        pre_spike = 1'b0;
        checks++;
        if (input_current !== 8'd50 || pre_trace !== (LEARN ? 8'd20 : 8'd0)) begin
            errors++;
            $display("FAIL current_spike: cur=%0d pt=%0d want 50/%0d",
                     input_current, pre_trace, LEARN ? 20 : 0);
        end
        for (int k = 1; k <= 21; k++) begin
            tick();
            checks++;
            if (input_current !== 8'd0 || weight !== 8'd50 ||
                pre_trace !== (LEARN ? 8'((k > 20) ? 0 : 20 - k) : 8'd0)) begin
                errors++;
                $display("FAIL trace_decay k=%0d: cur=%0d w=%0d pt=%0d want 0/50/%0d",
                         k, input_current, weight, pre_trace,
                         LEARN ? ((k > 20) ? 0 : 20 - k) : 0);
            end
        end
    endtask

    task automatic test_ltp();
        learn_en = 1'b1;
        load_weight(8'd50);
        pre_spike = 1'b1;
        tick();
        idle(4);
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        checks++;
        if (weight !== (LEARN ? 8'd54 : 8'd50)) begin
            errors++;
            $display("FAIL ltp_near: w=%0d want %0d", weight, LEARN ? 54 : 50);
        end
        idle(25);
        load_weight(8'd50);
        pre_spike = 1'b1;
        tick();
        idle(24);
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        checks++;
        if (weight !== 8'd50) begin
            errors++;
            $display("FAIL ltp_expired: w=%0d want 50", weight);
        end
        idle(25);
    endtask

    task automatic test_ltd();
        learn_en = 1'b1;
        load_weight(8'd50);
        post_spike = 1'b1;
        tick();
        idle(2);
        pre_spike = 1'b1;
        tick();
        pre_spike = 1'b0;
        checks++;
        if (input_current !== 8'd50 || weight !== (LEARN ? 8'd47 : 8'd50)) begin
            errors++;
            $display("FAIL ltd: cur=%0d w=%0d want 50/%0d",
                     input_current, weight, LEARN ? 47 : 50);
        end
        idle(25);
    endtask

    task automatic test_clamps();
        learn_en = 1'b1;
        load_weight(8'd253);
        pre_spike = 1'b1;
        tick();
        pre_spike  = 1'b0;
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        checks++;
        if (weight !== (LEARN ? 8'd255 : 8'd253)) begin
            errors++;
            $display("FAIL clamp_high: w=%0d want %0d", weight, LEARN ? 255 : 253);
        end
        idle(25);
        load_weight(8'd2);
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        pre_spike  = 1'b1;
        tick();
        pre_spike = 1'b0;
        checks++;
        if (weight !== (LEARN ? 8'd0 : 8'd2)) begin
            errors++;
            $display("FAIL clamp_low: w=%0d want %0d", weight, LEARN ? 0 : 2);
        end
        idle(25);
        load_weight(8'd230);
        checks++;
        if (c2_weight !== 8'd200 || weight !== 8'd230) begin
            errors++;
            $display("FAIL load_clamp: wmax200=%0d full=%0d want 200/230",
                     c2_weight, weight);
        end
    endtask

    task automatic test_coincidence(input bit with_load);
        load_weight(8'd50);
        idle(25);
        learn_en  = 1'b0;
        pre_spike = 1'b1;
        tick();
        pre_spike  = 1'b0;
        post_spike = 1'b1;
        tick();
        learn_en    = 1'b1;
        pre_spike   = 1'b1;
        post_spike  = 1'b1;
        weight_load = with_load;
        weight_din  = 8'd9;
        tick();
        clear_inputs();
        checks++;
        if (input_current !== 8'd50 ||
            weight !== (with_load ? 8'd9 : (LEARN ? 8'd51 : 8'd50))) begin
            errors++;
            $display("FAIL coincide load=%0d: cur=%0d w=%0d want 50/%0d", with_load,
                     input_current, weight, with_load ? 9 : (LEARN ? 51 : 50));
        end
        checks++;
        if (pre_trace !== (LEARN ? 8'd20 : 8'd0) || post_trace !== (LEARN ? 8'd20 : 8'd0)) begin
            errors++;
            $display("FAIL coincide_traces load=%0d: pt=%0d qt=%0d want %0d",
                     with_load, pre_trace, post_trace, LEARN ? 20 : 0);
        end
        idle(25);
    endtask

    task automatic test_back_to_back();
        learn_en = 1'b0;
        load_weight(8'd60);
        pre_spike   = 1'b1;
        weight_load = 1'b1;
        weight_din  = 8'd70;
        tick();
        weight_load = 1'b0;
        checks++;
        if (input_current !== 8'd60 || weight !== 8'd70) begin
            errors++;
            $display("FAIL b2b_first: cur=%0d w=%0d want 60/70", input_current, weight);
        end
        tick();
        pre_spike = 1'b0;
        checks++;
        if (input_current !== 8'd70) begin
            errors++;
            $display("FAIL b2b_second: cur=%0d want 70", input_current);
        end
        tick();
        checks++;
        if (input_current !== 8'd0) begin
            errors++;
            $display("FAIL b2b_idle: cur=%0d want 0", input_current);
        end
    endtask

    task automatic test_reset_midop();
        load_weight(8'd9);
        pre_spike = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (weight !== 8'd50 || input_current !== 8'd0 || pre_trace !== 8'd0) begin
            errors++;
            $display("FAIL reset_midop: w=%0d cur=%0d pt=%0d want 50/0/0",
                     weight, input_current, pre_trace);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (weight !== 8'd50 || input_current !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: w=%0d cur=%0d want 50/0", weight, input_current);
        end
    endtask

    initial begin
        clear_inputs();
        learn_en = 1'b0;
        test_reset();
        test_current_and_trace();
        test_ltp();
        test_ltd();
        test_clamps();
        test_coincidence(1'b0);
        test_coincidence(1'b1);
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stdp_synapse.md
# stdp_synapse

Single plastic synapse that converts a presynaptic spike into a one-cycle input current equal to its stored weight, and adapts that weight online with trace-based pair STDP. It sits directly upstream of the LIF neuron: `input_current` drives the neuron's `input_current`, and the neuron's `spike_out` returns as `post_spike`. Weight can also be written by the host for initialisation or test.

## Interface
- `INIT_WEIGHT`, 8'd50: weight after reset.
- `W_MAX`, 8'd255: upper weight clamp. The lower clamp is fixed at 0.
- `A_PLUS`, 8'd4: LTP step, applied on a post spike while `pre_trace` is nonzero.
- `A_MINUS`, 8'd3: LTD step, applied on a pre spike while `post_trace` is nonzero.
- `TRACE_MAX`, 8'd20: value a trace is loaded with on its spike.
- `TRACE_DECAY`, 8'd1: per-cycle trace decrement, saturating at 0.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pre_spike`  in  1  presynaptic spike, one cycle per spike.
- `post_spike`  in  1  postsynaptic spike (neuron `spike_out`).
- `learn_en`  in  1  runtime STDP enable.
- `weight_load`  in  1  host weight write strobe.
- `weight_din`  in  8  host weight value.
- `input_current`  out  8  registered current to the neuron.
- `weight`  out  8  current weight register.
- `pre_trace`  out  8  presynaptic eligibility trace.
- `post_trace`  out  8  postsynaptic eligibility trace.

## Operation
- Reset values: `weight` = `INIT_WEIGHT`. `input_current`, `pre_trace` and `post_trace` are all 0.
- Current path:
  - When `pre_spike` = 1, `input_current` <= `weight` (the pre-edge value). Otherwise `input_current` <= 0.
  - A weight change made in the same cycle as the spike does not affect that spike's current.
- Traces, each independent:
  - On its spike, the trace <= `TRACE_MAX`.
  - Otherwise, the trace <= max(trace − `TRACE_DECAY`, 0), computed 9-bit with underflow clamp.
  - Traces update regardless of `learn_en`.
- STDP (only when `learn_en` = 1), evaluated on the pre-edge trace values:
  - LTP term = `A_PLUS` if `post_spike` and `pre_trace` ≠ 0, else 0.
  - LTD term = `A_MINUS` if `pre_spike` and `post_trace` ≠ 0, else 0.
  - Sum = {0,weight} + LTP − LTD, computed as 10-bit signed.
  - If sum < 0, weight <= 0. If sum > `W_MAX`, weight <= `W_MAX`. Otherwise weight <= sum.
- Coincident pre and post in the same cycle: both terms apply, using the old traces. A spike's own trace load never qualifies its own pairing.
- `weight_load` has priority over STDP: weight <= min(`weight_din`, `W_MAX`). Traces still update normally in that cycle.

## Timing
- Current latency is 1 cycle: `pre_spike` high in cycle n gives `input_current` = weight in cycle n+1 for exactly one cycle.
- Back-to-back pre spikes give back-to-back currents, each carrying the weight as of its own cycle.
- Weight, trace and load updates are visible 1 cycle after the causing input.
- Trace expiry: a spike in cycle n leaves the trace nonzero through cycle n + ceil(`TRACE_MAX`/`TRACE_DECAY`). With defaults that is n+20, and the trace is 0 from n+21.
- Reset asserted mid-operation clears state immediately. The first update occurs on the first edge after deassertion.

## Configuration
- `STDP_LEARN_EN` defined: trace and STDP logic are built as described above.
- `STDP_LEARN_EN` undefined:
  - The weight changes only via `weight_load`.
  - `learn_en` and `post_spike` are ignored.
  - `pre_trace` and `post_trace` are tied to 0.
  - The current path is unchanged.

## Test plan
- Reset: pulse `rst_n` low with random inputs -> `weight` = 50 and all other outputs 0 during and after reset.
- Drive `pre_spike` for one cycle with `learn_en` = 0 -> `input_current` = 50 for exactly one cycle, then 0. `pre_trace` reads 20, 19, 18, … down to 0, and `weight` stays 50.
- LTP: `learn_en` = 1, pre at cycle 0, post at cycle 5 -> `weight` = 54. Post at cycle 25 instead -> `weight` stays 50.
- LTD: post at cycle 0, pre at cycle 3 -> `input_current` = 50 on that spike, and `weight` = 47 on the next cycle.
- Clamps:
  - Load 253 then LTP -> 255.
  - Load 2 then LTD -> 0.
  - With `W_MAX` = 200, load 230 -> `weight` = 200.
- Coincidence and priority:
  - Both traces nonzero, pre and post in the same cycle at weight 50 -> 51.
  - Same stimulus plus `weight_load` with `weight_din` = 9 -> 9.
